// File: rtl/cipher_pkg.sv
// Shared types and bit-manipulation helpers for the Feistel cipher engine.
// Helpers work on a 64-bit container with an explicit active width w (w <= 64).
package cipher_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUND = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Rotate the low w bits of v left by n (mod w); bits above w return as zero.
    function automatic logic [63:0] rotl(input logic [63:0] v, input int unsigned w,
                                         input int unsigned n);
        logic [63:0] mask;
        logic [63:0] vm;
        int unsigned s;
        mask = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
        vm   = v & mask;
        s    = n % w;
        if (s == 0) begin
            return vm;
        end
        return ((vm << s) | (vm >> (w - s))) & mask;
    endfunction

    // Reverse the order of the low w bits of v; bits above w return as zero.
    function automatic logic [63:0] bitrev(input logic [63:0] v, input int unsigned w);
        logic [63:0] o;
        o = '0;
        for (int unsigned i = 0; i < 64; i++) begin
            if (i < w) begin
                o = o | (((v >> i) & 64'd1) << (w - 1 - i));
            end
        end
        return o;
    endfunction

endpackage

// File: rtl/feistel_cipher_core_if.sv
// Block-level handshake bundle for the Feistel cipher engine: input side
// (in_valid/in_ready, din, key) and output side (out_valid/out_ready, dout, busy).
interface feistel_cipher_core_if #(
    parameter int unsigned HW = 4
);
    logic              in_valid;
    logic              in_ready;
    logic [2*HW-1:0]   din;
    logic [2*HW-1:0]   key;
    logic              out_valid;
    logic              out_ready;
    logic [2*HW-1:0]   dout;
    logic              busy;

    modport master (
        output in_valid, din, key, out_ready,
        input  in_ready, out_valid, dout, busy
    );

    modport slave (
        input  in_valid, din, key, out_ready,
        output in_ready, out_valid, dout, busy
    );
endinterface

// File: rtl/cipher_round.sv
// One combinational Feistel round: F(R,k) folded with a carry-select add, then L/R swap.
// E = {bitrev(R), rotl(R,1)}, X = E ^ k, S = X_hi + X_lo + k[0] (mod 2^HW).
// Requires 2 <= HW <= 32.
module cipher_round
    import cipher_pkg::*;
#(
    parameter int unsigned HW = 4
) (
    input  logic [HW-1:0]   l,
    input  logic [HW-1:0]   r,
    input  logic [2*HW-1:0] rk,
    output logic [HW-1:0]   l_next,
    output logic [HW-1:0]   r_next
);
    localparam int unsigned LO  = HW / 2;
    localparam int unsigned HI  = HW - LO;
    localparam int unsigned LOC = LO + 1;

    logic [2*HW-1:0] e;
    logic [2*HW-1:0] x;
    logic [HW-1:0]   xa;
    logic [HW-1:0]   xb;
    logic [LO:0]     sum_lo;
    logic [HI-1:0]   hi0;
    logic [HI-1:0]   hi1;
    logic [HW-1:0]   s;

    // Round function: expand, key-mix, carry-select fold, swap halves.
    always_comb begin
        e      = {HW'(bitrev(64'(r), HW)), HW'(rotl(64'(r), HW, 1))};
        x      = e ^ rk;
        xa     = x[2*HW-1:HW];
        xb     = x[HW-1:0];
        sum_lo = {1'b0, xa[LO-1:0]} + {1'b0, xb[LO-1:0]} + LOC'(rk[0]);
        hi0    = xa[HW-1:LO] + xb[HW-1:LO];
        hi1    = xa[HW-1:LO] + xb[HW-1:LO] + HI'(1);
        s      = {(sum_lo[LO] ? hi1 : hi0), sum_lo[LO-1:0]};
        l_next = r;
        r_next = l ^ s;
    end
endmodule

// File: rtl/feistel_cipher_core.sv
// Iterative Feistel cipher engine: ROUNDS rounds, one per cycle, valid/ready on both sides.
// Round i uses key rotated left by i; output is {R,L} to undo the final swap.
// Optional feature macro: CIPHER_DECRYPT_EN adds a 'decrypt' input, sampled at accept,
// which reverses the round-key order so the same datapath recovers plaintext.
module feistel_cipher_core
    import cipher_pkg::*;
#(
    parameter int unsigned HW     = 4,
    parameter int unsigned ROUNDS = 4
) (
    input  logic                 clock,
    input  logic                 reset,
`ifdef CIPHER_DECRYPT_EN
    input  logic                 decrypt,
`endif
    feistel_cipher_core_if.slave bus
);
    localparam int unsigned DW = 2 * HW;
    localparam int unsigned CW = (ROUNDS > 1) ? $clog2(ROUNDS) : 1;

    state_t          state_q;
    state_t          state_d;
    logic [HW-1:0]   l_q;
    logic [HW-1:0]   r_q;
    logic [HW-1:0]   l_nx;
    logic [HW-1:0]   r_nx;
    logic [DW-1:0]   key_q;
    logic [DW-1:0]   rk;
    logic [CW-1:0]   cnt_q;
    logic [CW-1:0]   kidx;
    logic            accept;
    logic            last_round;
`ifdef CIPHER_DECRYPT_EN
    logic            dec_q;
`endif

    assign accept     = (state_q == IDLE) && bus.in_valid;
    assign last_round = (cnt_q == CW'(ROUNDS - 1));
    assign bus.dout   = {r_q, l_q};

    // Round key for the current round: rotate the master key by the round index.
    always_comb begin
`ifdef CIPHER_DECRYPT_EN
        kidx = dec_q ? (CW'(ROUNDS - 1) - cnt_q) : cnt_q;
`else
        kidx = cnt_q;
`endif
        rk = DW'(rotl(64'(key_q), DW, 32'(kidx)));
    end

    cipher_round #(.HW(HW)) u_round (
        .l      (l_q),
        .r      (r_q),
        .rk     (rk),
        .l_next (l_nx),
        .r_next (r_nx)
    );

    // FSM state register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and handshake outputs.
    always_comb begin
        state_d       = state_q;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        bus.busy      = 1'b0;
        unique case (state_q)
            IDLE: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid) begin
                    state_d = ROUND;
                end
            end
            ROUND: begin
                bus.busy = 1'b1;
                if (last_round) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                bus.busy      = 1'b1;
                bus.out_valid = 1'b1;
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Datapath: load on accept, advance one round per ROUND cycle, hold otherwise.
    always_ff @(posedge clock) begin
        if (reset) begin
            l_q   <= '0;
            r_q   <= '0;
            key_q <= '0;
            cnt_q <= '0;
`ifdef CIPHER_DECRYPT_EN
            dec_q <= 1'b0;
`endif
        end else if (accept) begin
            l_q   <= bus.din[DW-1:HW];
            r_q   <= bus.din[HW-1:0];
            key_q <= bus.key;
            cnt_q <= '0;
`ifdef CIPHER_DECRYPT_EN
            dec_q <= decrypt;
`endif
        end else if (state_q == ROUND) begin
            l_q   <= l_nx;
            r_q   <= r_nx;
            cnt_q <= cnt_q + CW'(1);
        end
    end
endmodule

// File: tb/tb_feistel_cipher_core.sv
// Self-checking bench for feistel_cipher_core: two HW=4 instances (ROUNDS=1 and ROUNDS=4),
// hand-computed vector table, multi-cycle corner sequences and randomized blocks checked
// against an arithmetic reference model. Decrypt checks appear when CIPHER_DECRYPT_EN is defined.
module tb_feistel_cipher_core;

    logic clock = 1'b0;
    logic reset;

    always #5 clock = ~clock;

    feistel_cipher_core_if #(.HW(4)) bus_a ();
    feistel_cipher_core_if #(.HW(4)) bus_b ();

`ifdef CIPHER_DECRYPT_EN
    logic dec_a;
    logic dec_b;
`endif

    feistel_cipher_core #(.HW(4), .ROUNDS(1)) u_r1 (
        .clock   (clock),
        .reset   (reset),
`ifdef CIPHER_DECRYPT_EN
        .decrypt (dec_a),
`endif
        .bus     (bus_a.slave)
    );

    feistel_cipher_core #(.HW(4), .ROUNDS(4)) u_r4 (
        .clock   (clock),
        .reset   (reset),
`ifdef CIPHER_DECRYPT_EN
        .decrypt (dec_b),
`endif
        .bus     (bus_b.slave)
    );

    int unsigned n_cmp  = 0;
    int unsigned n_fail = 0;

    typedef struct packed {
        logic       sel;   // 0: ROUNDS=1 instance, 1: ROUNDS=4 instance
        logic [7:0] din;
        logic [7:0] key;
        logic [7:0] exp;
    } vec_t;

    vec_t vecs [5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference F on 4-bit halves, 8-bit round key, straight from the arithmetic definition.
    function automatic int unsigned ref_f(input int unsigned r, input int unsigned k);
        int unsigned rev;
        int unsigned rot;
        int unsigned x;
        rev = 0;
        for (int unsigned b = 0; b < 4; b++) begin
            if (((r >> b) & 1) != 0) rev = rev | (1 << (3 - b));
        end
        rot = ((r << 1) | (r >> 3)) & 15;
        x   = ((rev << 4) | rot) ^ k;
        return ((x >> 4) + (x & 15) + (k & 1)) % 16;
    endfunction

    function automatic logic [7:0] ref_cipher(input logic [7:0] din, input logic [7:0] key,
                                              input int unsigned rounds, input bit dec);
        int unsigned l;
        int unsigned r;
        int unsigned t;
        int unsigned ki;
        int unsigned k8;
        int unsigned rk;
        l  = 32'(din) >> 4;
        r  = 32'(din) & 15;
        k8 = 32'(key);
        for (int unsigned i = 0; i < rounds; i++) begin
            ki = (dec ? (rounds - 1 - i) : i) % 8;
            rk = ((k8 << ki) | (k8 >> (8 - ki))) & 255;
            t  = l ^ ref_f(r, rk);
            l  = r;
            r  = t;
        end
        return 8'((r << 4) | l);
    endfunction

    function automatic logic get_ov(input bit sel);
        return sel ? bus_b.out_valid : bus_a.out_valid;
    endfunction
    function automatic logic get_ir(input bit sel);
        return sel ? bus_b.in_ready : bus_a.in_ready;
    endfunction
    function automatic logic get_busy(input bit sel);
        return sel ? bus_b.busy : bus_a.busy;
    endfunction
    function automatic logic [7:0] get_dout(input bit sel);
        return sel ? bus_b.dout : bus_a.dout;
    endfunction

    task automatic drive_in(input bit sel, input logic v, input logic [7:0] d, input logic [7:0] k);
        if (sel) begin
            bus_b.in_valid = v;
            bus_b.din      = d;
            bus_b.key      = k;
        end else begin
            bus_a.in_valid = v;
            bus_a.din      = d;
            bus_a.key      = k;
        end
    endtask

    task automatic set_ordy(input bit sel, input logic v);
        if (sel) bus_b.out_ready = v;
        else     bus_a.out_ready = v;
    endtask

    // Offer a block, check the round phase, and wait (bounded) for out_valid.
    task automatic start_and_wait(input bit sel, input logic [7:0] d, input logic [7:0] k);
        int unsigned lat;
        int unsigned exp_lat;
        exp_lat = sel ? 4 : 1;
        @(negedge clock);
        check("in_ready_idle", 32'(get_ir(sel)), 32'd1);
        drive_in(sel, 1'b1, d, k);
        @(negedge clock);
        drive_in(sel, 1'b0, 8'h00, 8'h00);
        check("busy_round", 32'(get_busy(sel)), 32'd1);
        check("in_ready_round", 32'(get_ir(sel)), 32'd0);
        lat = 0;
        while (!get_ov(sel) && lat < 20) begin
            @(negedge clock);
            lat++;
        end
        check("latency", lat, exp_lat);
    endtask

    task automatic drain(input bit sel, output logic [7:0] res);
        res = get_dout(sel);
        set_ordy(sel, 1'b1);
        @(negedge clock);
        set_ordy(sel, 1'b0);
        check("out_valid_drop", 32'(get_ov(sel)), 32'd0);
        check("in_ready_back", 32'(get_ir(sel)), 32'd1);
    endtask

    task automatic run_block(input bit sel, input logic [7:0] d, input logic [7:0] k,
                             output logic [7:0] res);
        start_and_wait(sel, d, k);
        drain(sel, res);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [7:0] res;
        logic [7:0] d;
        logic [7:0] k;
        logic       seen_ov;

        vecs[0] = '{sel: 1'b0, din: 8'h46, key: 8'h93, exp: 8'hB6};
        vecs[1] = '{sel: 1'b0, din: 8'h00, key: 8'h01, exp: 8'h20};
        vecs[2] = '{sel: 1'b0, din: 8'hFF, key: 8'h00, exp: 8'h1F};
        vecs[3] = '{sel: 1'b1, din: 8'h00, key: 8'h00, exp: 8'h00};
        vecs[4] = '{sel: 1'b1, din: 8'h00, key: 8'h01, exp: 8'h84};

        reset = 1'b1;
        drive_in(1'b0, 1'b0, 8'h00, 8'h00);
        drive_in(1'b1, 1'b0, 8'h00, 8'h00);
        set_ordy(1'b0, 1'b0);
        set_ordy(1'b1, 1'b0);
`ifdef CIPHER_DECRYPT_EN
        dec_a = 1'b0;
        dec_b = 1'b0;
`endif
        repeat (2) @(negedge clock);
        for (int s = 0; s < 2; s++) begin
            check("rst_in_ready", 32'(get_ir(s[0])), 32'd1);
            check("rst_out_valid", 32'(get_ov(s[0])), 32'd0);
            check("rst_dout", 32'(get_dout(s[0])), 32'd0);
            check("rst_busy", 32'(get_busy(s[0])), 32'd0);
        end
        reset = 1'b0;

        // Known-answer vectors.
        for (int i = 0; i < 5; i++) begin
            run_block(vecs[i].sel, vecs[i].din, vecs[i].key, res);
            check("vector", 32'(res), 32'(vecs[i].exp));
        end

        // Backpressure: output held, new offers ignored while DONE.
        start_and_wait(1'b1, 8'h00, 8'h01);
        for (int i = 0; i < 10; i++) begin
            drive_in(1'b1, 1'b1, 8'h55, 8'h33);
            @(negedge clock);
            check("bp_out_valid", 32'(get_ov(1'b1)), 32'd1);
            check("bp_dout", 32'(get_dout(1'b1)), 32'h84);
            check("bp_in_ready", 32'(get_ir(1'b1)), 32'd0);
        end
        drive_in(1'b1, 1'b0, 8'h00, 8'h00);
        drain(1'b1, res);
        check("bp_result", 32'(res), 32'h84);
        run_block(1'b1, 8'h46, 8'h93, res);
        check("after_bp", 32'(res), 32'(ref_cipher(8'h46, 8'h93, 4, 1'b0)));

        // Reset during round 2 of 4 aborts the block.
        @(negedge clock);
        drive_in(1'b1, 1'b1, 8'hFF, 8'h5A);
        @(negedge clock);
        drive_in(1'b1, 1'b0, 8'h00, 8'h00);
        repeat (2) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        check("abort_in_ready", 32'(get_ir(1'b1)), 32'd1);
        check("abort_busy", 32'(get_busy(1'b1)), 32'd0);
        check("abort_out_valid", 32'(get_ov(1'b1)), 32'd0);
        check("abort_dout", 32'(get_dout(1'b1)), 32'd0);
        seen_ov = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clock);
            if (get_ov(1'b1)) seen_ov = 1'b1;
        end
        check("abort_no_ov", 32'(seen_ov), 32'd0);
        run_block(1'b1, 8'hC3, 8'h2E, res);
        check("after_abort", 32'(res), 32'(ref_cipher(8'hC3, 8'h2E, 4, 1'b0)));

        // Randomized blocks against the reference model.
        for (int i = 0; i < 32; i++) begin
            d = 8'($urandom);
            k = 8'($urandom);
            run_block(i[0], d, k, res);
            check(i[0] ? "rand_r4" : "rand_r1", 32'(res),
                  32'(ref_cipher(d, k, i[0] ? 4 : 1, 1'b0)));
        end

`ifdef CIPHER_DECRYPT_EN
        dec_a = 1'b1;
        run_block(1'b0, 8'hB6, 8'h93, res);
        dec_a = 1'b0;
        check("dec_vector", 32'(res), 32'h46);
        for (int i = 0; i < 16; i++) begin
            logic [7:0] ct;
            d = 8'($urandom);
            k = 8'($urandom);
            run_block(i[0], d, k, ct);
            if (i[0]) dec_b = 1'b1;
            else      dec_a = 1'b1;
            run_block(i[0], ct, k, res);
            dec_a = 1'b0;
            dec_b = 1'b0;
            check("roundtrip", 32'(res), 32'(d));
        end
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
